// File: rtl/dct4_sau_sched.sv
// 4-point DCT-II row sequencer; one shared 36x/83x shift-add unit serves both odd inputs, 3-cycle accept-to-valid.
// Holds outputs while out_ready is low and accepts back-to-back rows from DONE; DCT4_ROUND_SHIFT_EN adds rounding >>> SHIFT.
module dct4_sau_sched #(
  parameter int IN_W  = 12,
  parameter int SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] x0,
  input  logic signed [IN_W-1:0] x1,
  input  logic signed [IN_W-1:0] x2,
  input  logic signed [IN_W-1:0] x3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [19:0]     y0,
  output logic signed [19:0]     y1,
  output logic signed [19:0]     y2,
  output logic signed [19:0]     y3,
  output logic                   busy
);

  if (IN_W < 2 || IN_W > 12 || SHIFT < 1 || SHIFT > 8) begin : g_bad_param
    $error("dct4_sau_sched: IN_W must be 2..12 and SHIFT 1..8");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_MUL0, ST_MUL1, ST_DONE} state_t;

  typedef struct packed {
    logic [12:0] s0;
    logic [12:0] s1;
    logic [12:0] d0;
    logic [12:0] d1;
  } row_t;

  state_t             r_state;
  row_t               r_row;
  logic signed [19:0] r_p36, r_p83;
  logic signed [19:0] r_y0, r_y1, r_y2, r_y3;

  logic signed [12:0] w_x0e, w_x1e, w_x2e, w_x3e;
  row_t               w_row_in;
  logic               w_in_ready, w_accept;
  logic signed [12:0] w_sau_in;
  logic signed [19:0] w_sau_x, w_sau36, w_sau83;
  logic signed [13:0] w_esum, w_ediff;
  logic signed [19:0] w_y0_raw, w_y1_raw, w_y2_raw, w_y3_raw;
  logic signed [19:0] w_y0_nxt, w_y1_nxt, w_y2_nxt, w_y3_nxt;

  assign w_x0e = {{(13-IN_W){x0[IN_W-1]}}, x0};
  assign w_x1e = {{(13-IN_W){x1[IN_W-1]}}, x1};
  assign w_x2e = {{(13-IN_W){x2[IN_W-1]}}, x2};
  assign w_x3e = {{(13-IN_W){x3[IN_W-1]}}, x3};

  always_comb begin
    w_row_in    = '0;
    w_row_in.s0 = w_x0e + w_x3e;
    w_row_in.s1 = w_x1e + w_x2e;
    w_row_in.d0 = w_x0e - w_x3e;
    w_row_in.d1 = w_x1e - w_x2e;
  end

  assign w_in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept   = in_valid & w_in_ready;

  always_comb begin
    w_sau_in = '0;
    case (r_state)
      ST_MUL0: w_sau_in = $signed(r_row.d0);
      ST_MUL1: w_sau_in = $signed(r_row.d1);
      default: w_sau_in = '0;
    endcase
  end

  // sau_2o_1: unregistered shift-add, 36x = 32x+4x, 83x = 64x+16x+2x+x
  assign w_sau_x = {{7{w_sau_in[12]}}, w_sau_in};
  assign w_sau36 = (w_sau_x <<< 5) + (w_sau_x <<< 2);
  assign w_sau83 = (w_sau_x <<< 6) + (w_sau_x <<< 4) + (w_sau_x <<< 1) + w_sau_x;

  assign w_esum   = $signed({r_row.s0[12], r_row.s0}) + $signed({r_row.s1[12], r_row.s1});
  assign w_ediff  = $signed({r_row.s0[12], r_row.s0}) - $signed({r_row.s1[12], r_row.s1});
  assign w_y0_raw = {w_esum, 6'b0};
  assign w_y2_raw = {w_ediff, 6'b0};
  assign w_y1_raw = r_p83 + w_sau36;
  assign w_y3_raw = r_p36 - w_sau83;

`ifdef DCT4_ROUND_SHIFT_EN
  // One extra bit keeps the half-LSB add from wrapping at the positive extreme.
  function automatic logic signed [19:0] f_round(input logic signed [19:0] v);
    logic signed [20:0] t;
    t = {v[19], v} + 21'(1 << (SHIFT - 1));
    return 20'(t >>> SHIFT);
  endfunction

  assign w_y0_nxt = f_round(w_y0_raw);
  assign w_y1_nxt = f_round(w_y1_raw);
  assign w_y2_nxt = f_round(w_y2_raw);
  assign w_y3_nxt = f_round(w_y3_raw);
`else
  assign w_y0_nxt = w_y0_raw;
  assign w_y1_nxt = w_y1_raw;
  assign w_y2_nxt = w_y2_raw;
  assign w_y3_nxt = w_y3_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_p36   <= '0;
      r_p83   <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_y2    <= '0;
      r_y3    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_row   <= w_row_in;
            r_state <= ST_MUL0;
          end
        end
        ST_MUL0: begin
          r_p36   <= w_sau36;
          r_p83   <= w_sau83;
          r_state <= ST_MUL1;
        end
        ST_MUL1: begin
          r_y0    <= w_y0_nxt;
          r_y1    <= w_y1_nxt;
          r_y2    <= w_y2_nxt;
          r_y3    <= w_y3_nxt;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (w_accept) begin
            r_row   <= w_row_in;
            r_state <= ST_MUL0;
          end else if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign y0        = r_y0;
  assign y1        = r_y1;
  assign y2        = r_y2;
  assign y3        = r_y3;

endmodule

// File: tb/tb_dct4_sau_sched.sv
// Bench for dct4_sau_sched: DCT reference model with queue scoreboard plus literal spot values.
module tb_dct4_sau_sched;
  localparam int IN_W  = 12;
  localparam int SHIFT = 3;

`ifdef DCT4_ROUND_SHIFT_EN
  localparam int IMP1[4] = '{8, 10, 8, 5};
  localparam int IMP2[4] = '{8, 5, -8, -10};
  localparam int EXT1[4] = '{-16, 60913, 0, -24058};
  localparam int EXT2[4] = '{-16, 0, 65520, 0};
`else
  localparam int IMP1[4] = '{64, 83, 64, 36};
  localparam int IMP2[4] = '{64, 36, -64, -83};
  localparam int EXT1[4] = '{-128, 487305, 0, -192465};
  localparam int EXT2[4] = '{-128, 0, 524160, 0};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic signed [IN_W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic signed [19:0] y0, y1, y2, y3;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_xfer = 0;
  bit armed = 1'b0;
  bit prev_rst = 1'b0;

  typedef struct packed {
    int y0;
    int y1;
    int y2;
    int y3;
    int due;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  dct4_sau_sched #(.IN_W(IN_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .busy(busy)
  );

  function automatic int rnd(input int v);
`ifdef DCT4_ROUND_SHIFT_EN
    return (v + (1 << (SHIFT - 1))) >>> SHIFT;
`else
    return v;
`endif
  endfunction

  // Direct DCT-II definition with the integer cosine weights 64/83/36.
  function automatic exp_t model(input int a, input int b, input int c, input int d);
    exp_t e;
    e.y0  = rnd(64 * (a + b + c + d));
    e.y1  = rnd(83 * (a - d) + 36 * (b - c));
    e.y2  = rnd(64 * (a - b - c + d));
    e.y3  = rnd(36 * (a - d) - 83 * (b - c));
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  task automatic chk_y(input string nm, input int e[4]);
    chk({nm, "_y0"}, y0, e[0]);
    chk({nm, "_y1"}, y1, e[1]);
    chk({nm, "_y2"}, y2, e[2]);
    chk({nm, "_y3"}, y3, e[3]);
  endtask

  // Scoreboard: a row is due 3 negedges after the negedge preceding its accept edge.
  always @(negedge clk) begin
    bit   ev, eir;
    exp_t e;
    if (armed) begin
      ev  = (q.size() > 0) && (cyc >= q[0].due);
      eir = (q.size() == 0) || (ev && out_ready);
      chk("sb_out_valid", out_valid, ev);
      chk("sb_in_ready", in_ready, eir);
      chk("sb_busy", busy, q.size() != 0);
      if (prev_rst) begin
        chk("sb_rst_y0", y0, 0);
        chk("sb_rst_y1", y1, 0);
        chk("sb_rst_y2", y2, 0);
        chk("sb_rst_y3", y3, 0);
      end else if (ev) begin
        chk("sb_y0", y0, q[0].y0);
        chk("sb_y1", y1, q[0].y1);
        chk("sb_y2", y2, q[0].y2);
        chk("sb_y3", y3, q[0].y3);
      end
      if (!rst_n) begin
        q.delete();
      end else begin
        if (ev && out_ready) begin
          void'(q.pop_front());
          n_xfer++;
        end
        if (in_valid && eir) begin
          e     = model(x0, x1, x2, x3);
          e.due = cyc + 3;
          q.push_back(e);
          n_acc++;
        end
      end
    end
    if (!rst_n) armed = 1'b1;
    prev_rst = !rst_n;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic signed [IN_W-1:0] rand_x();
    if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 0) ? -(1 <<< (IN_W - 1)) : (1 <<< (IN_W - 1)) - 1;
    return IN_W'($urandom_range(0, (1 << IN_W) - 1));
  endfunction

  task automatic send(input int a, input int b, input int c, input int d);
    bit acc = 1'b0;
    tick();
    x0 = IN_W'(a); x1 = IN_W'(b); x2 = IN_W'(c); x3 = IN_W'(d);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int lat = 0;
    bit seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    chk({nm, "_latency"}, seen ? lat : -1, 3);
  endtask

  initial begin
    int prev, got, t;
    bit acc;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_y0", y0, 0);
    tick();
    rst_n = 1'b1;

    // Impulse with output held off, then a row offered together with out_ready.
    out_ready = 1'b0;
    send(1, 0, 0, 0);
    wait_valid("imp1");
    chk_y("imp1", IMP1);
    chk("imp1_in_ready_held", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_y("hold", IMP1);
      chk("hold_busy", busy, 1);
      chk("hold_out_valid", out_valid, 1);
    end
    tick();
    x0 = 0; x1 = 1; x2 = 0; x3 = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_valid("imp2");
    chk_y("imp2", IMP2);

    send(2047, 2047, -2048, -2048);
    wait_valid("ext1");
    chk_y("ext1", EXT1);
    send(2047, -2048, -2048, 2047);
    wait_valid("ext2");
    chk_y("ext2", EXT2);

    // Eight streamed rows: accepts must land exactly 3 cycles apart.
    tick();
    out_ready = 1'b1;
    x0 = rand_x(); x1 = rand_x(); x2 = rand_x(); x3 = rand_x();
    in_valid = 1'b1;
    prev = -1; got = 0; t = 0;
    while (got < 8 && t < 100) begin
      @(negedge clk);
      t++;
      acc = in_ready;
      if (acc) begin
        if (prev >= 0) chk("stream_gap", t - prev, 3);
        prev = t;
        got++;
      end
      tick();
      if (acc) begin
        x0 = rand_x(); x1 = rand_x(); x2 = rand_x(); x3 = rand_x();
      end
    end
    in_valid = 1'b0;
    chk("stream_rows", got, 8);
    repeat (6) tick();
    chk("stream_drained_xfer", n_xfer, n_acc);

    // Randomised valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x0 = rand_x(); x1 = rand_x(); x2 = rand_x(); x3 = rand_x();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("random_drained_xfer", n_xfer, n_acc);

    // Reset while the row sits in MUL1.
    out_ready = 1'b0;
    send(5, -3, 7, 100);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_y1", y1, 0);
    chk("midrst_y3", y3, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_output", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dct4_sau_sched.md
Name: dct4_sau_sched

Overview:
- Sequencer for a 4-point forward DCT-II that time-shares one `sau_2o_1` shift-add unit (X → 36·X, 83·X) across both odd-part inputs.
- Accepts one 4-sample row per transaction and produces all four coefficients.
- The even part uses ×64 shifts; the odd part issues two serialized SAU operations.
- Sits between the row feeder and the transpose buffer in the 2-D DCT path.

Parameters:
- IN_W, 12, signed input sample width; legal range 2..12 because the SAU input is fixed at 13 bits.
- SHIFT, 3, right shift applied only when the optional feature is compiled in; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  row available
- in_ready  out  1  block can accept a row
- x0, x1, x2, x3  in  IN_W each  signed input samples
- out_valid  out  1  y0..y3 valid
- out_ready  in  1  consumer accepts outputs
- y0, y1, y2, y3  out  20 each  signed DCT coefficients
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state updates occur on the rising edge of clk.
- Reset (rst_n=0 at an edge): state=IDLE; out_valid=0; y0..y3=0; busy=0; internal registers=0. A reset mid-operation discards the row in flight and emits no output.
- Handshakes are valid/ready; a transfer occurs on the edge where valid&ready=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready.
- out_valid=1 only in DONE. y0..y3 are held stable while out_valid=1 & out_ready=0.
- On input accept, register the following, sign-extended to 13 bits:
  - s0=x0+x3, s1=x1+x2
  - d0=x0-x3, d1=x1-x2
  - state→MUL0
- MUL0 (1 cycle): SAU input=d0; register p36=36·d0 and p83=83·d0; state→MUL1.
- MUL1 (1 cycle): SAU input=d1; register the outputs; state→DONE.
  - y0=64·(s0+s1)
  - y2=64·(s0−s1)
  - y1=p83+36·d1
  - y3=p36−83·d1
- DONE: hold outputs.
  - If out_ready & in_valid: accept the new row, state→MUL0 (back-to-back, no bubble).
  - If out_ready & !in_valid: state→IDLE.
  - Otherwise remain in DONE.
- SAU input mux drives 0 in IDLE and DONE.
- Latency: accept edge to out_valid is 3 cycles. Maximum throughput is 1 row per 3 cycles.
- Width rules:
  - All arithmetic is signed, two's complement, sign-extended before add/sub.
  - 20 bits is exact for the IN_W=12 extremes (|y| ≤ 524288), so there is no overflow or saturation logic.
- Illegal state encodings recover to IDLE on the next edge.
- SAU products are consumed in the same cycle they are produced; the SAU itself is not registered.

Optional Feature:
- Macro name: DCT4_ROUND_SHIFT_EN.
- Defined:
  - Each coefficient is rounded: y = (raw + (1<<(SHIFT−1))) >>> SHIFT, an arithmetic shift, sign-extended back to 20 bits.
  - The rounding adders sit in the MUL1→DONE register stage, so latency is unchanged.
- Undefined: the raw unshifted coefficients are output and the SHIFT parameter is ignored.

Test Plan:
- Impulse: x=(1,0,0,0), no macro → after 3 cycles, y=(64,83,64,36), out_valid=1, in_ready=0 while out_ready=0.
- Second impulse: x=(0,1,0,0) → y=(64,36,−64,−83).
- Extremes: x=(2047,2047,−2048,−2048) → y=(−128,487305,0,−192465); x=(2047,−2048,−2048,2047) → y=(−128,0,524160,0).
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → y stable, busy=1.
  - Then assert out_ready together with in_valid → new row accepted on the same edge, next out_valid 3 cycles later.
  - No lost or duplicated rows over 8 streamed rows.
- Reset mid-operation: drop rst_n=0 during MUL1 → next edge out_valid=0, y=0, state IDLE, in_ready=1, no output for the aborted row.
- DCT4_ROUND_SHIFT_EN with SHIFT=3:
  - x=(1,0,0,0) → y=(8,10,8,5).
  - x=(0,1,0,0) → y=(8,5,−8,−10), confirming negative rounding: (−83+4)>>>3=−10.
